// File: rtl/ahb_arbiter_pkg.sv
// rtl/ahb_arbiter_pkg.sv - shared HTRANS encodings, master indices and arbiter FSM states
package ahb_arbiter_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [1:0] MASTER_CPU = 2'd0;
   localparam logic [1:0] MASTER_DMA = 2'd1;
   localparam logic [1:0] MASTER_ACC = 2'd2;

   typedef enum logic {
      ST_IDLE,
      ST_OWNED
   } arb_state_t;

endpackage

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - per-master request/address/data inputs and muxed bus outputs of the arbiter
interface ahb_arbiter_if #(
   parameter int W = 32
) ();
   logic [2:0]   hbusreq_m;
   logic [1:0]   htrans_m0, htrans_m1, htrans_m2;
   logic [W-1:0] haddr_m0, haddr_m1, haddr_m2;
   logic         hwrite_m0, hwrite_m1, hwrite_m2;
   logic [2:0]   hsize_m0, hsize_m1, hsize_m2;
   logic [W-1:0] hwdata_m0, hwdata_m1, hwdata_m2;
   logic         hready_in;

   logic [2:0]   hgrant;
   logic [1:0]   hmaster;
   logic [1:0]   HTRANS;
   logic [W-1:0] HADDR;
   logic         HWRITE;
   logic [2:0]   HSIZE;
   logic [W-1:0] HWDATA;

   modport master (
      output hbusreq_m, htrans_m0, htrans_m1, htrans_m2, haddr_m0, haddr_m1, haddr_m2,
             hwrite_m0, hwrite_m1, hwrite_m2, hsize_m0, hsize_m1, hsize_m2,
             hwdata_m0, hwdata_m1, hwdata_m2, hready_in,
      input  hgrant, hmaster, HTRANS, HADDR, HWRITE, HSIZE, HWDATA
   );

   modport slave (
      input  hbusreq_m, htrans_m0, htrans_m1, htrans_m2, haddr_m0, haddr_m1, haddr_m2,
             hwrite_m0, hwrite_m1, hwrite_m2, hsize_m0, hsize_m1, hsize_m2,
             hwdata_m0, hwdata_m1, hwdata_m2, hready_in,
      output hgrant, hmaster, HTRANS, HADDR, HWRITE, HSIZE, HWDATA
   );
endinterface

// File: rtl/ahb_arbiter_rr_pick3.sv
// rtl/ahb_arbiter_rr_pick3.sv - round-robin pick among three requests, searching from (last + 1) mod 3
module rr_pick3
   import ahb_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] grant,
   output logic       valid
);

   always_comb begin
      grant = 3'b000;
      case (last)
         MASTER_CPU: begin
            if (req[1])      grant = 3'b010;
            else if (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
         end
         MASTER_DMA: begin
            if (req[2])      grant = 3'b100;
            else if (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
         end
         default: begin
            if (req[0])      grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
         end
      endcase
   end

   assign valid = |req;

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - three-master AHB arbiter: round-robin grant, muxed address and data phases
// Defining AHB_ARB_TIMEOUT_EN adds a BURST_MAX beat limit that forces rearbitration.
module ahb_arbiter
   import ahb_arbiter_pkg::*;
#(
   parameter int W         = 32,
   parameter int BURST_MAX = 16
) (
   input logic          HCLK,
   input logic          HRESET,
   ahb_arbiter_if.slave bus
);

   arb_state_t   state, state_nxt;
   logic [2:0]   hgrant_q, hgrant_nxt;
   logic [1:0]   hmaster_q, hmaster_nxt;
   logic [1:0]   last_q, last_nxt;
   logic [1:0]   dphase_owner;
   htrans_t      owner_trans;
   logic [W-1:0] haddr_sel, hwdata_sel;
   logic         hwrite_sel;
   logic [2:0]   hsize_sel;
   logic         owner_req, timeout, rearb;
   logic [2:0]   pick_grant;
   logic         pick_valid;
   logic [1:0]   pick_idx;

   rr_pick3 u_rr_pick3 (
      .req   (bus.hbusreq_m),
      .last  (last_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   always_comb begin
      owner_trans = htrans_t'(bus.htrans_m0);
      haddr_sel   = bus.haddr_m0;
      hwrite_sel  = bus.hwrite_m0;
      hsize_sel   = bus.hsize_m0;
      case (hmaster_q)
         MASTER_DMA: begin
            owner_trans = htrans_t'(bus.htrans_m1);
            haddr_sel   = bus.haddr_m1;
            hwrite_sel  = bus.hwrite_m1;
            hsize_sel   = bus.hsize_m1;
         end
         MASTER_ACC: begin
            owner_trans = htrans_t'(bus.htrans_m2);
            haddr_sel   = bus.haddr_m2;
            hwrite_sel  = bus.hwrite_m2;
            hsize_sel   = bus.hsize_m2;
         end
         default: ;
      endcase
   end

   always_comb begin
      hwdata_sel = bus.hwdata_m0;
      case (dphase_owner)
         MASTER_DMA: hwdata_sel = bus.hwdata_m1;
         MASTER_ACC: hwdata_sel = bus.hwdata_m2;
         default:    ;
      endcase
   end

   assign bus.HTRANS  = (state == ST_IDLE) ? HTRANS_IDLE : owner_trans;
   assign bus.HADDR   = haddr_sel;
   assign bus.HWRITE  = hwrite_sel;
   assign bus.HSIZE   = hsize_sel;
   assign bus.HWDATA  = hwdata_sel;
   assign bus.hgrant  = hgrant_q;
   assign bus.hmaster = hmaster_q;

   assign owner_req = |(bus.hbusreq_m & hgrant_q);

`ifdef AHB_ARB_TIMEOUT_EN
   logic [4:0] beat_cnt, beat_cnt_inc;

   always_comb begin
      beat_cnt_inc = beat_cnt;
      if (state == ST_OWNED && owner_trans != HTRANS_IDLE && beat_cnt != 5'd31)
         beat_cnt_inc = beat_cnt + 5'd1;
   end

   // Including the beat accepted on this edge hands over right after beat BURST_MAX.
   assign timeout = ({27'd0, beat_cnt_inc} >= $unsigned(BURST_MAX))
                    && ((bus.hbusreq_m & ~hgrant_q) != 3'b000);

   always_ff @(posedge HCLK) begin
      if (HRESET)
         beat_cnt <= 5'd0;
      else if (bus.hready_in)
         beat_cnt <= rearb ? 5'd0 : beat_cnt_inc;
   end
`else
   logic unused_burst_max;
   assign unused_burst_max = ^BURST_MAX;
   assign timeout          = 1'b0;
`endif

   assign rearb = bus.hready_in && (state == ST_IDLE || owner_trans == HTRANS_IDLE
                                    || !owner_req || timeout);

   always_comb begin
      pick_idx = MASTER_CPU;
      case (pick_grant)
         3'b010:  pick_idx = MASTER_DMA;
         3'b100:  pick_idx = MASTER_ACC;
         default: pick_idx = MASTER_CPU;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      hgrant_nxt  = hgrant_q;
      hmaster_nxt = hmaster_q;
      last_nxt    = last_q;
      if (rearb) begin
         if (pick_valid) begin
            state_nxt   = ST_OWNED;
            hgrant_nxt  = pick_grant;
            hmaster_nxt = pick_idx;
            last_nxt    = pick_idx;
         end else begin
            // Park on the CPU; the round-robin pointer keeps the last real owner.
            state_nxt   = ST_IDLE;
            hgrant_nxt  = 3'b001;
            hmaster_nxt = MASTER_CPU;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state        <= ST_IDLE;
         hgrant_q     <= 3'b001;
         hmaster_q    <= MASTER_CPU;
         last_q       <= MASTER_CPU;
         dphase_owner <= MASTER_CPU;
      end else begin
         state     <= state_nxt;
         hgrant_q  <= hgrant_nxt;
         hmaster_q <= hmaster_nxt;
         last_q    <= last_nxt;
         if (bus.hready_in)
            dphase_owner <= hmaster_q;
      end
   end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter W, default 32, sets the HADDR/HWDATA width.
REQ-002 Parameter BURST_MAX, default 16, sets the beat limit used only when AHB_ARB_TIMEOUT_EN is defined.
REQ-003 HCLK  in  1  bus clock; all state updates on the rising edge.
REQ-004 HRESET  in  1  synchronous, active-high reset.
REQ-005 hbusreq_m[2:0]  in  3  bus request per master (0=CPU, 1=DMA, 2=accelerator).
REQ-006 htrans_m0..m2  in  2 each  per-master HTRANS.
REQ-007 haddr_m0..m2  in  W each  per-master HADDR.
REQ-008 hwrite_m0..m2  in  1 each  per-master HWRITE.
REQ-009 hsize_m0..m2  in  3 each  per-master HSIZE.
REQ-010 hwdata_m0..m2  in  W each  per-master HWDATA.
REQ-011 hready_in  in  1  bus HREADY returned from the slave response mux.
REQ-012 hgrant[2:0]  out  3  one-hot address-phase grant.
REQ-013 hmaster  out  2  index of the address-phase owner, for the decoder.
REQ-014 HTRANS, HADDR, HWRITE, HSIZE  out  2/W/1/3  muxed address phase to the decoder and slaves.
REQ-015 HWDATA  out  W  write data muxed by the data-phase owner.

Function
REQ-016 Address/control outputs SHALL combinationally select the master indicated by hmaster.
REQ-017 HWDATA SHALL select the master in register dphase_owner, which loads hmaster on each HCLK edge with hready_in=1.
REQ-018 The FSM SHALL have states IDLE (no request, default master M0 parked, HTRANS forced IDLE=2'b00) and OWNED.
REQ-019 Rearbitration SHALL occur only on an edge with hready_in=1, and only if one of these holds: state is IDLE; the owner drives HTRANS=IDLE; the owner has deasserted hbusreq; or the timeout of REQ-030 fires.
REQ-020 On rearbitration, selection SHALL be round-robin starting from (last owner + 1) mod 3 among asserted hbusreq.
REQ-021 If no master requests at rearbitration, the FSM SHALL enter IDLE with hgrant=3'b001 and hmaster=0.
REQ-022 hgrant and hmaster SHALL change only on an edge with hready_in=1, so an address phase is never split.
REQ-023 While hready_in=0, all grant, owner and counter state SHALL hold.
REQ-024 A BUSY (2'b01) owner transfer SHALL NOT trigger rearbitration.
REQ-025 A SEQ owner transfer SHALL NOT trigger rearbitration except through the timeout of REQ-030.
REQ-026 A grant change SHALL take effect at the next address phase: the new owner's HTRANS appears on the bus in the cycle after the edge that changes hgrant.
REQ-027 If requests assert in the same cycle as the owner goes IDLE, arbitration SHALL use that cycle's hbusreq values.

Reset
REQ-028 On HRESET=1 at an HCLK edge: state=IDLE, hgrant=3'b001, hmaster=0, dphase_owner=0, round-robin pointer=0, beat counter=0.
REQ-029 Reset asserted mid-transfer SHALL discard the owner without waiting for hready_in.

Configuration
REQ-030 With macro AHB_ARB_TIMEOUT_EN defined: a 5-bit beat counter SHALL increment per accepted non-IDLE owner beat, reset to 0 on grant change, and force rearbitration at the next hready_in=1 edge once it reaches BURST_MAX while any other master requests.
REQ-031 With AHB_ARB_TIMEOUT_EN undefined, the counter SHALL be absent and the owner SHALL keep the bus until REQ-019's other conditions hold.

Structure
REQ-032 A shared package SHALL hold the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the master index constants and the FSM state enum.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick3 (inputs req[2:0] and last[1:0]; outputs grant one-hot and valid).

Verification
REQ-034 Scenario: reset, no requests -> hgrant=001, HTRANS=00, hmaster=0.
REQ-035 Scenario: M1 requests; NONSEQ 0x2000_0000 write 0xDEAD_BEEF -> hgrant=010 next edge; HADDR=0x2000_0000 following cycle; HWDATA=0xDEAD_BEEF in data phase.
REQ-036 Scenario: M0 and M2 request together after M1 was last owner -> M2 granted first; M0 granted after M2 drives IDLE.
REQ-037 Scenario: hready_in=0 for 3 cycles while M0 releases and M1 requests -> hgrant unchanged until hready_in=1, then 010.
REQ-038 Scenario: HRESET mid-burst of M2 -> next cycle hgrant=001, dphase_owner=0.
REQ-039 Scenario: AHB_ARB_TIMEOUT_EN defined, M0 issues a 20-beat SEQ burst while M1 requests -> grant moves to M1 after beat 16; undefined -> M0 keeps all 20 beats.
